seqsig_gen: RTL and testbench
=============================

# seqsig_gen

Periodic serial-sequence generator built from three independent circular shift registers: `shiftreg6`, `shiftreg4` and `shiftreg3`. Each sub-block emits a fixed bit pattern on a single output, one bit per clock, repeating forever. The top wrapper `seqsig_gen` instantiates all three on a shared clock and reset. The block serves as a pattern/stimulus source for downstream serial logic.

## Interface
Parameters (top `seqsig_gen`, passed to each sub-block as `PAT`):
- `PAT6`, default 6'b100111: period-6 pattern, MSB emitted first.
- `PAT4`, default 4'b1101: period-4 pattern, MSB emitted first.
- `PAT3`, default 3'b110: period-3 pattern, MSB emitted first.

Ports (top):
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `q6`  output  1  serial output of `shiftreg6`.
- `q4`  output  1  serial output of `shiftreg4`.
- `q3`  output  1  serial output of `shiftreg3`.

Sub-blocks `shiftreg6` / `shiftreg4` / `shiftreg3` each have:
- Ports: `clk` (in, 1), `rst` (in, 1), `q` (out, 1).
- Parameter: `PAT`, width N = 6, 4 or 3 respectively.

## Operation
- Each sub-block holds an N-bit register `sr`.
- `q` = `sr[N-1]`, driven directly from the register with no combinational path from inputs.
- Rising edge of `clk` with `rst`=1: `sr` <= `PAT`.
- Rising edge of `clk` with `rst`=0: `sr` <= {`sr[N-2:0]`, `sr[N-1]`}, a rotate left by one.
- The pattern therefore never decays. There is no external serial input and no feedback logic other than the rotate.
- Output sequences after reset release, starting with the reset-cycle value:
  - `q6`: 1,0,0,1,1,1, repeating.
  - `q4`: 1,1,0,1, repeating.
  - `q3`: 1,1,0, repeating.
- The three generators are fully independent and share only `clk` and `rst`.
- Any non-zero `PAT` is legal. `PAT` = 0 yields constant 0 and is permitted.

## Timing
- Reset values: `sr` = `PAT`, and `q6`=1, `q4`=1, `q3`=1 with default parameters.
- `rst` is sampled only at rising edges. Asserting `rst` between edges has no effect until the next edge.
- While `rst` is held high, all outputs stay frozen at `PAT[N-1]`.
- Latency:
  - The first edge with `rst`=0 presents `PAT[N-2]` on `q`.
  - After k non-reset edges, `q` = `PAT[(N-1-k) mod N]`.
  - Periods are exactly 6, 4 and 3 cycles. The joint pattern of (`q6`,`q4`,`q3`) repeats every 12 cycles.
- Reset asserted mid-sequence: at the next edge all registers reload `PAT` regardless of phase. The sequence restarts from its first bit after release.
- Before the first reset edge, register contents are undefined. A reset is required for a defined output.
- Outputs change only after rising edges and are glitch-free.

## Test plan
- Reset hold: `rst`=1 for 5 edges -> `q6`=`q4`=`q3`=1 after the first edge and stable throughout.
- Free run: after reset, release `rst` for 24 edges -> cycle by cycle:
  - `q6` = 1,0,0,1,1,1 repeated.
  - `q4` = 1,1,0,1 repeated.
  - `q3` = 1,1,0 repeated.
- Joint period: sample (`q6`,`q4`,`q3`) at cycle k and k+12 for k = 0..11 -> identical. Cycle 6 differs from cycle 0: cycle 0 is (1,1,1), cycle 6 is (1,0,1).
- Mid-sequence reset: release for 4 edges (`q6`=1, `q4`=1, `q3`=1), pulse `rst` for 1 edge -> all outputs 1. On the next non-reset edge, `q6`=0, `q4`=1, `q3`=1.
- Sub-cycle reset pulse: toggle `rst` high then low between two edges -> no reload, and the rotation continues uninterrupted.
- Parameter override: `PAT4`=4'b1000 -> `q4` = 1,0,0,0 repeating, with other outputs unchanged.

Source files
------------

// File: rtl/seqsig_gen.sv
`default_nettype none
// ============================================================================
// Module   : seqsig_gen (with sub-blocks shiftreg6, shiftreg4, shiftreg3)
// Purpose  : Periodic serial-sequence generator. Three independent circular
//            shift registers each emit a fixed bit pattern, MSB first, one
//            bit per clock. The patterns repeat forever.
// Ports    : clk  - clock; all state changes on its rising edge
//            rst  - synchronous active-high reset; reloads every pattern
//            q6   - serial output of the period-6 generator
//            q4   - serial output of the period-4 generator
//            q3   - serial output of the period-3 generator
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// shiftreg6 : period-6 circular shift register; q = sr[5]
// ----------------------------------------------------------------------------
module shiftreg6 #(
    parameter logic [5:0] PAT = 6'b100111
) (
    input  logic clk,
    input  logic rst,
    output logic q
);
    localparam int c_WIDTH = 6;

    logic [c_WIDTH-1:0] sr_q;
    logic [c_WIDTH-1:0] sr_d;

    // Rotate left: the bit just shown wraps to the bottom, so nothing decays.
    always_comb begin
        sr_d = {sr_q[c_WIDTH-2:0], sr_q[c_WIDTH-1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= PAT;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q = sr_q[c_WIDTH-1];
endmodule

// ----------------------------------------------------------------------------
// shiftreg4 : period-4 circular shift register; q = sr[3]
// ----------------------------------------------------------------------------
module shiftreg4 #(
    parameter logic [3:0] PAT = 4'b1101
) (
    input  logic clk,
    input  logic rst,
    output logic q
);
    localparam int c_WIDTH = 4;

    logic [c_WIDTH-1:0] sr_q;
    logic [c_WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = {sr_q[c_WIDTH-2:0], sr_q[c_WIDTH-1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= PAT;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q = sr_q[c_WIDTH-1];
endmodule

// ----------------------------------------------------------------------------
// shiftreg3 : period-3 circular shift register; q = sr[2]
// ----------------------------------------------------------------------------
module shiftreg3 #(
    parameter logic [2:0] PAT = 3'b110
) (
    input  logic clk,
    input  logic rst,
    output logic q
);
    localparam int c_WIDTH = 3;

    logic [c_WIDTH-1:0] sr_q;
    logic [c_WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = {sr_q[c_WIDTH-2:0], sr_q[c_WIDTH-1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= PAT;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q = sr_q[c_WIDTH-1];
endmodule

// ----------------------------------------------------------------------------
// seqsig_gen : top wrapper; the three generators share only clk and rst
// ----------------------------------------------------------------------------
module seqsig_gen #(
    parameter logic [5:0] PAT6 = 6'b100111,
    parameter logic [3:0] PAT4 = 4'b1101,
    parameter logic [2:0] PAT3 = 3'b110
) (
    input  logic clk,
    input  logic rst,
    output logic q6,
    output logic q4,
    output logic q3
);
    shiftreg6 #(.PAT(PAT6)) u_shiftreg6 (
        .clk (clk),
        .rst (rst),
        .q   (q6)
    );

    shiftreg4 #(.PAT(PAT4)) u_shiftreg4 (
        .clk (clk),
        .rst (rst),
        .q   (q4)
    );

    shiftreg3 #(.PAT(PAT3)) u_shiftreg3 (
        .clk (clk),
        .rst (rst),
        .q   (q3)
    );
endmodule

`default_nettype wire

// File: tb/tb_seqsig_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_seqsig_gen
// Purpose  : Directed self-checking bench for seqsig_gen. A second instance
//            overrides PAT4 to 4'b1000 to exercise the parameter path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seqsig_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic q6, q4, q3;
    logic p6, p4, p3;

    int total = 0;
    int bad   = 0;

    // Hand-written expected sequences, index = cycles since reset release.
    bit e6  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bit e4  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    bit e3  [3] = '{1'b1, 1'b1, 1'b0};
    bit e4b [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

    logic [2:0] hist [25];

    always #5 clk = ~clk;

    seqsig_gen u_dut (
        .clk (clk),
        .rst (rst),
        .q6  (q6),
        .q4  (q4),
        .q3  (q3)
    );

    seqsig_gen #(.PAT4(4'b1000)) u_dut_ovr (
        .clk (clk),
        .rst (rst),
        .q6  (p6),
        .q4  (p4),
        .q3  (p3)
    );

    // Advance one rising edge and settle 1 ns past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({q6, q4, q3} !== 3'b111) begin
                bad++;
                $display("FAIL reset_hold edge=%0d got=%b exp=111", i, {q6, q4, q3});
            end
            total++;
            if ({p6, p4, p3} !== 3'b111) begin
                bad++;
                $display("FAIL reset_hold_ovr edge=%0d got=%b exp=111", i, {p6, p4, p3});
            end
        end
    endtask

    task automatic test_free_run();
        logic [2:0] exp;
        rst = 1'b1;
        tick();
        hist[0] = {q6, q4, q3};
        rst = 1'b0;
        for (int j = 1; j <= 24; j++) begin
            tick();
            hist[j] = {q6, q4, q3};
        end
        for (int j = 0; j <= 24; j++) begin
            exp = {e6[j % 6], e4[j % 4], e3[j % 3]};
            total++;
            if (hist[j] !== exp) begin
                bad++;
                $display("FAIL free_run cycle=%0d got=%b exp=%b", j, hist[j], exp);
            end
        end
        for (int k = 0; k < 12; k++) begin
            total++;
            if (hist[k + 12] !== hist[k]) begin
                bad++;
                $display("FAIL joint_period k=%0d got=%b exp=%b", k, hist[k + 12], hist[k]);
            end
        end
        total++;
        if (hist[0] !== 3'b111) begin
            bad++;
            $display("FAIL joint_cycle0 got=%b exp=111", hist[0]);
        end
        total++;
        if (hist[6] !== 3'b101) begin
            bad++;
            $display("FAIL joint_cycle6 got=%b exp=101", hist[6]);
        end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if ({q6, q4, q3} !== 3'b111) begin
            bad++;
            $display("FAIL mid_pre got=%b exp=111", {q6, q4, q3});
        end
        rst = 1'b1;
        tick();
        total++;
        if ({q6, q4, q3} !== 3'b111) begin
            bad++;
            $display("FAIL mid_reload got=%b exp=111", {q6, q4, q3});
        end
        rst = 1'b0;
        tick();
        total++;
        if ({q6, q4, q3} !== 3'b011) begin
            bad++;
            $display("FAIL mid_restart got=%b exp=011", {q6, q4, q3});
        end
    endtask

    task automatic test_subcycle_pulse();
        logic [2:0] exp;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        total++;
        if ({q6, q4, q3} !== 3'b011) begin
            bad++;
            $display("FAIL subcycle_pre got=%b exp=011", {q6, q4, q3});
        end
        // Pulse rst entirely between two rising edges.
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        for (int j = 2; j <= 6; j++) begin
            tick();
            exp = {e6[j % 6], e4[j % 4], e3[j % 3]};
            total++;
            if ({q6, q4, q3} !== exp) begin
                bad++;
                $display("FAIL subcycle_run cycle=%0d got=%b exp=%b", j, {q6, q4, q3}, exp);
            end
        end
    endtask

    task automatic test_param_override();
        logic [2:0] exp;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int j = 0; j < 8; j++) begin
            exp = {e6[j % 6], e4b[j % 4], e3[j % 3]};
            total++;
            if ({p6, p4, p3} !== exp) begin
                bad++;
                $display("FAIL param_ovr cycle=%0d got=%b exp=%b", j, {p6, p4, p3}, exp);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_mid_reset();
        test_subcycle_pulse();
        test_param_override();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
